// File: rtl/imm_pkg.sv
// Shared immediate-format encodings, also used by the control unit.
package imm_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Request/result handshake bundle for the registered immediate generator.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      Inst;
    logic [2:0]       ImmSrc;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  ImmExt;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    // Producer of requests and consumer of results.
    modport master (
        output in_valid, Inst, ImmSrc, in_tag, out_ready,
        input  in_ready, out_valid, ImmExt, out_err, out_tag
    );

    modport slave (
        input  in_valid, Inst, ImmSrc, in_tag, out_ready,
        output in_ready, out_valid, ImmExt, out_err, out_tag
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension for all RV32I/RV64I formats.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Built at 64 bits and truncated so XLEN=32 needs no zero-width replication.
    logic [63:0] wide;
    logic        unused_bits;

    assign unused_bits = ^{inst[6:0], wide};

    always_comb begin
        wide = '0;
        err  = 1'b0;
        case (imm_src)
            IMM_I: wide = {{52{inst[31]}}, inst[31:20]};
            IMM_S: wide = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: wide = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: wide = {{32{inst[31]}}, inst[31:12], 12'b0};
            IMM_J: wide = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z: wide = {59'b0, inst[19:15]};
            default: err = 1'b1;
        endcase
    end

    assign imm = wide[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode, output register plus one skid entry,
// tag pass-through and a saturating illegal-format counter.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    imm_gen_pipe_if.slave        bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [XLEN-1:0]      dec_imm;
    logic                 dec_err;

    logic                 out_valid_q;
    logic [XLEN-1:0]      out_imm_q;
    logic                 out_err_q;
    logic [TAG_W-1:0]     out_tag_q;

    logic                 skid_valid_q;
    logic [XLEN-1:0]      skid_imm_q;
    logic                 skid_err_q;
    logic [TAG_W-1:0]     skid_tag_q;

    logic                 in_ready_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic                 accept;
    logic                 drain;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst    (bus.Inst),
        .imm_src (bus.ImmSrc),
        .imm     (dec_imm),
        .err     (dec_err)
    );

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_err_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
            skid_tag_q   <= '0;
            in_ready_q   <= 1'b1;
            err_cnt_q    <= '0;
        end else begin
            // in_ready is low whenever the skid holds data, so accept and a full
            // skid never coincide.
            if (skid_valid_q) begin
                if (drain) begin
                    out_imm_q    <= skid_imm_q;
                    out_err_q    <= skid_err_q;
                    out_tag_q    <= skid_tag_q;
                    skid_valid_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end
            end else if (accept) begin
                if (!out_valid_q || bus.out_ready) begin
                    out_valid_q <= 1'b1;
                    out_imm_q   <= dec_imm;
                    out_err_q   <= dec_err;
                    out_tag_q   <= bus.in_tag;
                end else begin
                    skid_valid_q <= 1'b1;
                    skid_imm_q   <= dec_imm;
                    skid_err_q   <= dec_err;
                    skid_tag_q   <= bus.in_tag;
                    in_ready_q   <= 1'b0;
                end
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end

            if (accept && dec_err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ImmExt    = out_imm_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_tag   = out_tag_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32/ERR_CNT_W=2 and an XLEN=64/ERR_CNT_W=8 instance
// share stimulus and are checked every cycle against a queue-based reference.
module tb_imm_gen_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] err_cnt32;
    logic [7:0] err_cnt64;

    int checks = 0;
    int errors = 0;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) if64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(4), .ERR_CNT_W(2)) dut32 (
        .clk     (clk),
        .reset   (reset),
        .bus     (if32.slave),
        .err_cnt (err_cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4), .ERR_CNT_W(8)) dut64 (
        .clk     (clk),
        .reset   (reset),
        .bus     (if64.slave),
        .err_cnt (err_cnt64)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] imm;
        logic        err;
        logic [3:0]  tag;
    } ent_t;

    ent_t q[$];
    int   m_cnt32 = 0;
    int   m_cnt64 = 0;

    // Field value assembled arithmetically, then two's-complement sign extension.
    function automatic void ref_imm(input logic [31:0] inst, input logic [2:0] src,
                                    output logic [63:0] imm, output logic err);
        longint unsigned ui;
        longint          val;
        int              w;
        ui  = 64'(inst);
        val = 0;
        w   = 0;
        err = 1'b0;
        case (src)
            3'd0: begin val = longint'(ui >> 20); w = 12; end
            3'd1: begin val = longint'((ui >> 25) * 32 + ((ui >> 7) & 31)); w = 12; end
            3'd2: begin
                val = longint'(((ui >> 31) & 1) * 4096 + ((ui >> 7) & 1) * 2048
                      + ((ui >> 25) & 63) * 32 + ((ui >> 8) & 15) * 2);
                w = 13;
            end
            3'd3: begin val = longint'((ui >> 12) * 4096); w = 32; end
            3'd4: begin
                val = longint'(((ui >> 31) & 1) * 1048576 + ((ui >> 12) & 255) * 4096
                      + ((ui >> 20) & 1) * 2048 + ((ui >> 21) & 1023) * 2);
                w = 21;
            end
            3'd5: begin val = longint'((ui >> 15) & 31); w = 0; end
            default: err = 1'b1;
        endcase
        if (w > 0 && val >= (64'sd1 <<< (w - 1))) val = val - (64'sd1 <<< w);
        imm = 64'(val);
    endfunction

    always @(posedge clk) begin
        ent_t e;
        logic acc;
        logic drn;
        if (reset) begin
            q.delete();
            m_cnt32 = 0;
            m_cnt64 = 0;
        end else begin
            acc = if32.in_valid && (q.size() < 2);
            drn = (q.size() > 0) && if32.out_ready;
            if (drn) void'(q.pop_front());
            if (acc) begin
                ref_imm(if32.Inst, if32.ImmSrc, e.imm, e.err);
                e.tag = if32.in_tag;
                q.push_back(e);
                if (e.err) begin
                    if (m_cnt32 < 3) m_cnt32++;
                    if (m_cnt64 < 255) m_cnt64++;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [63:0] v;
        v = (q.size() > 0) ? 64'd1 : 64'd0;
        chk("out_valid32", 64'(if32.out_valid), v);
        chk("out_valid64", 64'(if64.out_valid), v);
        chk("in_ready32", 64'(if32.in_ready), (q.size() < 2) ? 64'd1 : 64'd0);
        chk("in_ready64", 64'(if64.in_ready), (q.size() < 2) ? 64'd1 : 64'd0);
        chk("err_cnt32", 64'(err_cnt32), 64'(m_cnt32));
        chk("err_cnt64", 64'(err_cnt64), 64'(m_cnt64));
        if (q.size() > 0) begin
            chk("imm32", 64'(if32.ImmExt), 64'(q[0].imm[31:0]));
            chk("imm64", if64.ImmExt, q[0].imm);
            chk("err32", 64'(if32.out_err), 64'(q[0].err));
            chk("err64", 64'(if64.out_err), 64'(q[0].err));
            chk("tag32", 64'(if32.out_tag), 64'(q[0].tag));
            chk("tag64", 64'(if64.out_tag), 64'(q[0].tag));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] src,
                         input logic [3:0] tag);
        if32.in_valid = v;  if64.in_valid = v;
        if32.Inst     = inst; if64.Inst   = inst;
        if32.ImmSrc   = src;  if64.ImmSrc = src;
        if32.in_tag   = tag;  if64.in_tag = tag;
    endtask

    task automatic set_ready(input logic r);
        if32.out_ready = r;
        if64.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a request until it is accepted; leaves in_valid low afterwards.
    task automatic send(input logic [31:0] inst, input logic [2:0] src, input logic [3:0] tag);
        logic got;
        int   n;
        n = 0;
        drive(1'b1, inst, src, tag);
        forever begin
            got = if32.in_ready;
            tick();
            if (got) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
                break;
            end
        end
        drive(1'b0, 32'h0, 3'h0, 4'h0);
    endtask

    task automatic expect_out(input string name, input logic [63:0] e64, input logic e_err,
                              input logic [3:0] e_tag);
        chk({name, "_valid"}, 64'(if32.out_valid & if64.out_valid), 64'd1);
        chk({name, "_imm32"}, 64'(if32.ImmExt), 64'(e64[31:0]));
        chk({name, "_imm64"}, if64.ImmExt, e64);
        chk({name, "_err"}, 64'({if32.out_err, if64.out_err}), e_err ? 64'd3 : 64'd0);
        chk({name, "_tag"}, 64'({if32.out_tag, if64.out_tag}), 64'({e_tag, e_tag}));
    endtask

    task automatic expect_idle(input string name);
        chk({name, "_valid"}, 64'({if32.out_valid, if64.out_valid}), 64'd0);
        chk({name, "_ready"}, 64'({if32.in_ready, if64.in_ready}), 64'd3);
        chk({name, "_imm"}, if64.ImmExt | 64'(if32.ImmExt), 64'd0);
        chk({name, "_err"}, 64'({if32.out_err, if64.out_err}), 64'd0);
        chk({name, "_tag"}, 64'({if32.out_tag, if64.out_tag}), 64'd0);
        chk({name, "_cnt"}, 64'({err_cnt32, err_cnt64}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic hold;
        logic acc;
        logic rst;

        drive(1'b0, 32'h0, 3'h0, 4'h0);
        set_ready(1'b1);
        reset = 1'b1;
        tick();
        tick();
        expect_idle("reset");
        reset = 1'b0;

        // Directed formats, back-to-back with out_ready high.
        send(32'hFFF00093, 3'b000, 4'd1);
        expect_out("i_type", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd1);
        send(32'hFE000EE3, 3'b010, 4'd2);
        expect_out("b_type", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 4'd2);
        send(32'h0010006F, 3'b100, 4'd3);
        expect_out("j_type", 64'h0000_0000_0000_0800, 1'b0, 4'd3);
        send(32'h800000B7, 3'b011, 4'd4);
        expect_out("u_type", 64'hFFFF_FFFF_8000_0000, 1'b0, 4'd4);
        send(32'h000F8073, 3'b101, 4'd5);
        expect_out("z_type", 64'h0000_0000_0000_001F, 1'b0, 4'd5);
        tick();

        // Backpressure: tag1 to output, tag2 to skid, tag3 held off.
        set_ready(1'b0);
        drive(1'b1, 32'h00100013, 3'b000, 4'd1);
        tick();
        drive(1'b1, 32'h00200013, 3'b000, 4'd2);
        tick();
        drive(1'b1, 32'h00300013, 3'b000, 4'd3);
        chk("bp_in_ready", 64'({if32.in_ready, if64.in_ready}), 64'd0);
        expect_out("bp_hold0", 64'd1, 1'b0, 4'd1);
        tick();
        tick();
        chk("bp_in_ready2", 64'({if32.in_ready, if64.in_ready}), 64'd0);
        expect_out("bp_hold2", 64'd1, 1'b0, 4'd1);
        set_ready(1'b1);
        tick();
        expect_out("bp_out2", 64'd2, 1'b0, 4'd2);
        chk("bp_in_ready3", 64'({if32.in_ready, if64.in_ready}), 64'd3);
        tick();
        drive(1'b0, 32'h0, 3'h0, 4'h0);
        expect_out("bp_out3", 64'd3, 1'b0, 4'd3);
        tick();

        // Illegal formats: dut32 counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            send($urandom, (i % 2 == 0) ? 3'b111 : 3'b110, 4'(i));
            expect_out("illegal", 64'd0, 1'b1, 4'(i));
        end
        chk("err_sat32", 64'(err_cnt32), 64'd3);
        chk("err_cnt64_5", 64'(err_cnt64), 64'd5);
        tick();

        // Reset with output and skid both full.
        set_ready(1'b0);
        send(32'h7FF00013, 3'b000, 4'd9);
        send(32'h00000013, 3'b000, 4'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_idle("mid_reset");
        set_ready(1'b1);
        send(32'h7FF00013, 3'b000, 4'd11);
        expect_out("post_reset", 64'h7FF, 1'b0, 4'd11);
        tick();

        // Randomised traffic; upstream holds a request until it is accepted.
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                if ($urandom_range(0, 3) != 0)
                    drive(1'b1, $urandom, 3'($urandom_range(0, 7)), 4'($urandom));
                else
                    drive(1'b0, $urandom, 3'($urandom_range(0, 7)), 4'($urandom));
            end
            set_ready((i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3));
            rst = ($urandom_range(0, 199) == 0);
            reset = rst;
            acc = if32.in_valid && if32.in_ready;
            tick();
            hold = if32.in_valid && !acc && !rst;
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 3'h0, 4'h0);
        set_ready(1'b1);
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
